// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage constants. The decode and hazard blocks use the same
// NOP encoding and PC step.
package instr_fetch_unit_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;
endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter. Update priority is reset, then redirect, then stall,
// then a normal +4 step. The adder wraps silently at 2^32.
module pc_register
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);
    logic [31:0] pc_q, pc_d;

    assign pc_plus4_o = pc_q + PC_STEP;
    assign pc_o       = pc_q;

    // A redirect overrides a stall, so the target is never lost.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i)
            pc_d = target_i & WORD_MASK;
        else if (!stall_i)
            pc_d = pc_plus4_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage. It drives the fetch address to the instruction memory and
// captures the returned word into the IF/ID register.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PCPlus4,
    output logic [31:0] IF_Instruction,
    output logic        IF_Valid
);
    logic [31:0] pc, pc_plus4;
    logic [31:0] if_pc_q, if_pc_d, if_pc4_q, if_pc4_d, if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;

    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .stall_i    (Stall),
        .redirect_i (Redirect),
        .target_i   (RedirectTarget),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4)
    );

    assign Address = pc & WORD_MASK;

    // On a redirect, the word fetched down the wrong path becomes a bubble.
    always_comb begin
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        if (Redirect) begin
            if_pc_d    = '0;
            if_pc4_d   = '0;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end else if (!Stall) begin
            if_pc_d    = pc;
            if_pc4_d   = pc_plus4;
            if_instr_d = Instruction;
            if_valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
        end else begin
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign IF_PC          = if_pc_q;
    assign IF_PCPlus4     = if_pc4_q;
    assign IF_Instruction = if_instr_q;
    assign IF_Valid       = if_valid_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit. The memory holds word i = i*3 and
// aliases on Address[8:2].
module tb_instr_fetch_unit;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] addr;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1, Stall = 1'b0, Redirect = 1'b0;
    logic [31:0] RedirectTarget = '0;
    logic [31:0] Address, Instruction, IF_PC, IF_PCPlus4, IF_Instruction;
    logic        IF_Valid;

    int   n_chk = 0, n_pass = 0;
    exp_t sb_q[$];

    // Reference state of the fetch stage.
    logic [31:0] m_pc;
    logic        m_pc_known = 1'b0;
    exp_t        m_ifid = '{32'd0, 32'd0, 32'd0, 1'b0, 32'd0};

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Stall          (Stall),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .Address        (Address),
        .Instruction    (Instruction),
        .IF_PC          (IF_PC),
        .IF_PCPlus4     (IF_PCPlus4),
        .IF_Instruction (IF_Instruction),
        .IF_Valid       (IF_Valid)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = {25'd0, a[8:2]};
        return idx * 32'd3;
    endfunction

    assign Instruction = mem_word(Address);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drives one cycle from the falling edge, then pushes the expected state
    // after the rising edge and compares it.
    task automatic step(input logic rst, input logic stl, input logic rdr, input logic [31:0] tgt);
        exp_t e, g;
        @(negedge Clk);
        Reset = rst; Stall = stl; Redirect = rdr; RedirectTarget = tgt;
        #1;
        if (m_pc_known) chk("addr_pre", Address, m_pc);
        if (rst) begin
            m_pc   = 32'h0000_0000;
            m_ifid = '{32'd0, 32'd0, 32'd0, 1'b0, 32'd0};
        end else if (rdr) begin
            m_ifid = '{32'd0, 32'd0, 32'd0, 1'b0, 32'd0};
            m_pc   = {tgt[31:2], 2'b00};
        end else if (!stl) begin
            m_ifid = '{m_pc, m_pc + 32'd4, mem_word(m_pc), 1'b1, 32'd0};
            m_pc   = m_pc + 32'd4;
        end
        m_pc_known = 1'b1;
        e = m_ifid;
        e.addr = m_pc;
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            g = sb_q.pop_front();
            chk("if_pc", IF_PC, g.pc);
            chk("if_pc4", IF_PCPlus4, g.pc4);
            chk("if_instr", IF_Instruction, g.instr);
            chk("if_valid", {31'd0, IF_Valid}, {31'd0, g.valid});
            chk("addr_post", Address, g.addr);
        end
    endtask

    initial begin
        // Reset, then a plain run: Address 0,4,8,C with data one cycle behind.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        // PC is now 0x10. Hold it for three cycles, then resume.
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        // Move to 0x0C, then redirect to 0x40 from there.
        step(0, 0, 1, 32'h0000_000C);
        step(0, 0, 1, 32'h0000_0040);
        repeat (2) step(0, 0, 0, 0);
        // A misaligned target together with a stall behaves as a redirect.
        step(0, 1, 1, 32'h0000_0043);
        step(0, 0, 0, 0);
        // Wrap from 0xFFFF_FFFC to 0.
        step(0, 0, 1, 32'hFFFF_FFFC);
        repeat (3) step(0, 0, 0, 0);
        // Redirect to the current PC (0x08) still inserts a bubble.
        step(0, 0, 1, 32'h0000_0008);
        step(0, 0, 0, 0);
        // Reset taken at PC 0x20 while Stall is high.
        step(0, 0, 1, 32'h0000_0020);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        // Random mix of stalls, redirects and an occasional reset.
        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0), $urandom);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
